// File: rtl/video_timing_pkg.sv
// Shared 720p60 video timing constants and region decoding for the signal
// generator and the HDMI top level.
package video_timing_pkg;

    localparam int unsigned DEF_ACTIVE_H_PIXELS = 1280;
    localparam int unsigned DEF_H_FRONT_PORCH   = 110;
    localparam int unsigned DEF_H_SYNC_WIDTH    = 40;
    localparam int unsigned DEF_H_BACK_PORCH    = 220;

    localparam int unsigned DEF_ACTIVE_LINES    = 720;
    localparam int unsigned DEF_V_FRONT_PORCH   = 5;
    localparam int unsigned DEF_V_SYNC_WIDTH    = 5;
    localparam int unsigned DEF_V_BACK_PORCH    = 20;

    localparam int unsigned DEF_FPS             = 60;

    localparam int unsigned H_TOTAL = DEF_ACTIVE_H_PIXELS + DEF_H_FRONT_PORCH
                                    + DEF_H_SYNC_WIDTH + DEF_H_BACK_PORCH;
    localparam int unsigned V_TOTAL = DEF_ACTIVE_LINES + DEF_V_FRONT_PORCH
                                    + DEF_V_SYNC_WIDTH + DEF_V_BACK_PORCH;

    // Regions of a line (in pixels) or of a frame (in lines), in scan order.
    typedef enum logic [1:0] {
        REGION_ACTIVE = 2'd0,
        REGION_FRONT  = 2'd1,
        REGION_SYNC   = 2'd2,
        REGION_BACK   = 2'd3
    } region_e;

    // Classify a counter position against the active/front/sync boundaries;
    // anything beyond the sync pulse is back porch.
    function automatic region_e region_of(
        input int unsigned cnt,
        input int unsigned active,
        input int unsigned front,
        input int unsigned sync
    );
        if (cnt < active) begin
            return REGION_ACTIVE;
        end else if (cnt < active + front) begin
            return REGION_FRONT;
        end else if (cnt < active + front + sync) begin
            return REGION_SYNC;
        end else begin
            return REGION_BACK;
        end
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX counter with increment enable. Resets to MAX-1 so that the
// first enabled edge after reset lands on 0. Exposes its next value so the
// parent can register flags that line up with the count.
module wrap_counter #(
    parameter  int unsigned MAX = 8,
    localparam int unsigned W   = $clog2(MAX)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_d_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: hold when disabled, otherwise step and wrap at MAX-1.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    // Count register, parked at MAX-1 while in reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= LAST;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign count_d_o = count_d;
    assign wrap_o    = en_i && (count_q == LAST);

endmodule

// File: rtl/video_sig_gen.sv
// Video timing generator: pixel/line counters plus registered sync,
// active-draw, new-frame and frame-count outputs that always describe the
// counts presented in the same cycle.
module video_sig_gen
    import video_timing_pkg::*;
#(
    parameter  int unsigned ACTIVE_H_PIXELS = DEF_ACTIVE_H_PIXELS,
    parameter  int unsigned H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
    parameter  int unsigned H_SYNC_WIDTH    = DEF_H_SYNC_WIDTH,
    parameter  int unsigned H_BACK_PORCH    = DEF_H_BACK_PORCH,
    parameter  int unsigned ACTIVE_LINES    = DEF_ACTIVE_LINES,
    parameter  int unsigned V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
    parameter  int unsigned V_SYNC_WIDTH    = DEF_V_SYNC_WIDTH,
    parameter  int unsigned V_BACK_PORCH    = DEF_V_BACK_PORCH,
    parameter  int unsigned FPS             = DEF_FPS,
    localparam int unsigned HT = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
    localparam int unsigned VT = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
    localparam int unsigned HW = $clog2(HT),
    localparam int unsigned VW = $clog2(VT),
    localparam int unsigned FW = $clog2(FPS)
) (
    input  logic          clk_pixel_in,
    input  logic          rst_in,
    output logic [HW-1:0] h_count_out,
    output logic [VW-1:0] v_count_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic          ad_out,
    output logic          nf_out,
    output logic [FW-1:0] fc_out
);

    logic [HW-1:0] h_d;
    logic [VW-1:0] v_d;
    logic          h_wrap;
    logic          v_wrap_unused;

    region_e       h_region_d;
    region_e       v_region_d;

    logic          hs_d, hs_q;
    logic          vs_d, vs_q;
    logic          ad_d, ad_q;
    logic          nf_d, nf_q;
    logic [FW-1:0] fc_d, fc_q;

    wrap_counter #(
        .MAX (HT)
    ) u_h_counter (
        .clk_i     (clk_pixel_in),
        .rst_i     (rst_in),
        .en_i      (1'b1),
        .count_o   (h_count_out),
        .count_d_o (h_d),
        .wrap_o    (h_wrap)
    );

    wrap_counter #(
        .MAX (VT)
    ) u_v_counter (
        .clk_i     (clk_pixel_in),
        .rst_i     (rst_in),
        .en_i      (h_wrap),
        .count_o   (v_count_out),
        .count_d_o (v_d),
        .wrap_o    (v_wrap_unused)
    );

    // Flags are decoded from the counters' next values and registered, so
    // they change on the same edge as the counts they describe.
    always_comb begin
        h_region_d = region_of(32'(h_d), ACTIVE_H_PIXELS, H_FRONT_PORCH, H_SYNC_WIDTH);
        v_region_d = region_of(32'(v_d), ACTIVE_LINES, V_FRONT_PORCH, V_SYNC_WIDTH);

        ad_d = (h_region_d == REGION_ACTIVE) && (v_region_d == REGION_ACTIVE);
        hs_d = (h_region_d == REGION_SYNC);
        vs_d = (v_region_d == REGION_SYNC);
        nf_d = (32'(h_d) == ACTIVE_H_PIXELS) && (32'(v_d) == ACTIVE_LINES);

        fc_d = fc_q;
        if (nf_d) begin
            fc_d = (32'(fc_q) == FPS - 1) ? '0 : fc_q + FW'(1);
        end
    end

    // Output flag and frame-counter registers, cleared asynchronously.
    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            ad_q <= 1'b0;
            nf_q <= 1'b0;
            fc_q <= '0;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            ad_q <= ad_d;
            nf_q <= nf_d;
            fc_q <= fc_d;
        end
    end

    assign hs_out = hs_q;
    assign vs_out = vs_q;
    assign ad_out = ad_q;
    assign nf_out = nf_q;
    assign fc_out = fc_q;

endmodule

// File: tb/tb_video_sig_gen.sv
// Directed bench for video_sig_gen: a small-parameter instance for frame
// level behaviour and a default 720p instance for reset and line boundaries.
module tb_video_sig_gen;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Small instance: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), FPS 4.
    logic [2:0]  s_h;
    logic [2:0]  s_v;
    logic        s_hs, s_vs, s_ad, s_nf;
    logic [1:0]  s_fc;

    // Default 720p60 instance.
    logic [10:0] d_h;
    logic [9:0]  d_v;
    logic        d_hs, d_vs, d_ad, d_nf;
    logic [5:0]  d_fc;

    int total = 0;
    int bad   = 0;

    video_sig_gen #(
        .ACTIVE_H_PIXELS (4),
        .H_FRONT_PORCH   (1),
        .H_SYNC_WIDTH    (2),
        .H_BACK_PORCH    (1),
        .ACTIVE_LINES    (3),
        .V_FRONT_PORCH   (1),
        .V_SYNC_WIDTH    (1),
        .V_BACK_PORCH    (1),
        .FPS             (4)
    ) u_small (
        .clk_pixel_in (clk),
        .rst_in       (rst),
        .h_count_out  (s_h),
        .v_count_out  (s_v),
        .hs_out       (s_hs),
        .vs_out       (s_vs),
        .ad_out       (s_ad),
        .nf_out       (s_nf),
        .fc_out       (s_fc)
    );

    video_sig_gen u_dflt (
        .clk_pixel_in (clk),
        .rst_in       (rst),
        .h_count_out  (d_h),
        .v_count_out  (d_v),
        .hs_out       (d_hs),
        .vs_out       (d_vs),
        .ad_out       (d_ad),
        .nf_out       (d_nf),
        .fc_out       (d_fc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_small_reset(input string tag);
        chk({tag, "_s_h"},  32'(s_h),  32'd7);
        chk({tag, "_s_v"},  32'(s_v),  32'd5);
        chk({tag, "_s_hs"}, 32'(s_hs), 32'd0);
        chk({tag, "_s_vs"}, 32'(s_vs), 32'd0);
        chk({tag, "_s_ad"}, 32'(s_ad), 32'd0);
        chk({tag, "_s_nf"}, 32'(s_nf), 32'd0);
        chk({tag, "_s_fc"}, 32'(s_fc), 32'd0);
    endtask

    task automatic chk_dflt_reset(input string tag);
        chk({tag, "_d_h"},  32'(d_h),  32'd1649);
        chk({tag, "_d_v"},  32'(d_v),  32'd749);
        chk({tag, "_d_hs"}, 32'(d_hs), 32'd0);
        chk({tag, "_d_vs"}, 32'(d_vs), 32'd0);
        chk({tag, "_d_ad"}, 32'(d_ad), 32'd0);
        chk({tag, "_d_nf"}, 32'(d_nf), 32'd0);
        chk({tag, "_d_fc"}, 32'(d_fc), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fc_tab[4];
        int nf_seen;
        int nfk;
        int eh, ev, ef, ep;

        fc_tab = '{1, 2, 3, 0};

        // Reset is visible before any clock edge.
        rst = 1'b1;
        #2;
        chk_small_reset("rst_async");
        chk_dflt_reset("rst_async");

        // Held through clock edges, values stay parked.
        tick();
        tick();
        chk_small_reset("rst_held");

        // First edge after release lands on the first active pixel.
        rst = 1'b0;
        tick();
        chk("first_s_h",  32'(s_h),  32'd0);
        chk("first_s_v",  32'(s_v),  32'd0);
        chk("first_s_ad", 32'(s_ad), 32'd1);
        chk("first_s_nf", 32'(s_nf), 32'd0);
        chk("first_s_fc", 32'(s_fc), 32'd0);
        chk("first_d_h",  32'(d_h),  32'd0);
        chk("first_d_v",  32'(d_v),  32'd0);
        chk("first_d_ad", 32'(d_ad), 32'd1);

        // Four full small frames (48 cycles each); new frame at (h=4, v=3).
        nf_seen = 0;
        nfk     = 0;
        for (int i = 0; i < 192; i++) begin
            eh = i % 8;
            ev = (i / 8) % 6;
            ef = i / 48;
            ep = i % 48;
            chk("loop_h",  32'(s_h),  32'(eh));
            chk("loop_v",  32'(s_v),  32'(ev));
            chk("loop_ad", 32'(s_ad), (eh < 4 && ev < 3) ? 32'd1 : 32'd0);
            chk("loop_hs", 32'(s_hs), (eh == 5 || eh == 6) ? 32'd1 : 32'd0);
            chk("loop_vs", 32'(s_vs), (ev == 4) ? 32'd1 : 32'd0);
            chk("loop_nf", 32'(s_nf), (ep == 28) ? 32'd1 : 32'd0);
            chk("loop_fc", 32'(s_fc), 32'((ef + ((ep >= 28) ? 1 : 0)) % 4));
            if (ep == 28) begin
                chk("fc_at_nf", 32'(s_fc), 32'(fc_tab[nfk]));
                nfk++;
            end
            if (s_nf === 1'b1) nf_seen++;
            tick();
        end
        chk("nf_pulse_count", 32'(nf_seen), 32'd4);

        // Move to h=2, v=1 and reset between edges.
        repeat (10) tick();
        chk("mid_s_h", 32'(s_h), 32'd2);
        chk("mid_s_v", 32'(s_v), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_small_reset("rst_mid");
        chk_dflt_reset("rst_mid");
        tick();
        rst = 1'b0;
        tick();
        chk("rel_s_h",  32'(s_h),  32'd0);
        chk("rel_s_v",  32'(s_v),  32'd0);
        chk("rel_s_ad", 32'(s_ad), 32'd1);
        chk("rel_s_nf", 32'(s_nf), 32'd0);
        chk("rel_s_fc", 32'(s_fc), 32'd0);

        // No new-frame pulse until the fresh frame reaches (h=4, v=3).
        nf_seen = 0;
        repeat (27) begin
            tick();
            if (s_nf === 1'b1) nf_seen++;
        end
        chk("no_spurious_nf", 32'(nf_seen), 32'd0);
        tick();
        chk("post_rst_nf_h", 32'(s_h),  32'd4);
        chk("post_rst_nf_v", 32'(s_v),  32'd3);
        chk("post_rst_nf",   32'(s_nf), 32'd1);
        chk("post_rst_fc",   32'(s_fc), 32'd1);

        // Default instance is now at h=28, v=0; walk its line boundaries.
        chk("d_h_28", 32'(d_h), 32'd28);
        repeat (1279 - 28) tick();
        chk("d_h_1279",  32'(d_h),  32'd1279);
        chk("d_ad_1279", 32'(d_ad), 32'd1);
        tick();
        chk("d_ad_1280", 32'(d_ad), 32'd0);
        chk("d_nf_1280", 32'(d_nf), 32'd0);
        repeat (1389 - 1280) tick();
        chk("d_h_1389",  32'(d_h),  32'd1389);
        chk("d_hs_1389", 32'(d_hs), 32'd0);
        tick();
        chk("d_hs_1390", 32'(d_hs), 32'd1);
        repeat (39) tick();
        chk("d_h_1429",  32'(d_h),  32'd1429);
        chk("d_hs_1429", 32'(d_hs), 32'd1);
        tick();
        chk("d_hs_1430", 32'(d_hs), 32'd0);
        repeat (1649 - 1430) tick();
        chk("d_h_1649",  32'(d_h),  32'd1649);
        chk("d_v_line0", 32'(d_v),  32'd0);
        tick();
        chk("d_h_wrap",  32'(d_h),  32'd0);
        chk("d_v_line1", 32'(d_v),  32'd1);
        chk("d_ad_l1",   32'(d_ad), 32'd1);
        chk("d_vs_l1",   32'(d_vs), 32'd0);
        chk("d_fc_l1",   32'(d_fc), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
